msk_g4_encoder: RTL and testbench

Streaming masking encoder for GF(4) elements. Takes an unmasked 2-bit element, splits it into a d-share Boolean sharing, and presents the sharing in the bit-sliced layout consumed by the masked GF(4) gadgets. Share bit 0 appears on `out0` and share bit 1 on `out1`, one lane per share. It sits at the input boundary of masked datapaths and in benches that drive gadget chains. Ready/valid handshakes are used on both sides.

---
 rtl/msk_g4_pkg.sv | 14 +
 rtl/msk_g4_prng_xs64.sv | 29 ++
 rtl/msk_g4_encoder.sv | 131 +++++++++++++
 tb/tb_msk_g4_encoder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msk_g4_pkg.sv
// Shared GF(4) masking definitions: element type, element width and the
// randomness budget of the d-share encoder.
package msk_g4_pkg;

  localparam int unsigned G4_W = 2;

  typedef logic [G4_W-1:0] g4_t;

  // Random bits consumed per encoded element: one fresh GF(4) mask per extra share.
  function automatic int unsigned g4_enc_n_rnd(input int unsigned d);
    return G4_W * (d - 1);
  endfunction

endpackage

// File: rtl/msk_g4_prng_xs64.sv
// xorshift64 generator (13/7/17); state reloads the seed on reset and advances
// once per step.
module msk_g4_prng_xs64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  input  logic [63:0] seed,
  output logic [63:0] state
);

  logic [63:0] s1;
  logic [63:0] s2;
  logic [63:0] nxt;

  always_comb begin
    s1  = state ^ (state << 13);
    s2  = s1 ^ (s1 >> 7);
    nxt = s2 ^ (s2 << 17);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= seed;
    end else if (step) begin
      state <= nxt;
    end
  end

endmodule

// File: rtl/msk_g4_encoder.sv
// Streaming d-share Boolean masking encoder for GF(4), bit-sliced output lanes.
// Build option: define MSK_ENC_PRNG_EN to source masks from the internal xorshift64.
`ifndef DEFAULTSHARES
`define DEFAULTSHARES 2
`endif

module msk_g4_encoder
  import msk_g4_pkg::*;
#(
  parameter int unsigned d         = `DEFAULTSHARES,
  parameter logic [63:0] PRNG_SEED = 64'h0123456789ABCDEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [G4_W-1:0]              in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [g4_enc_n_rnd(d)-1:0]   rnd,
  input  logic                         rnd_valid,
  output logic                         rnd_ready,
  output logic [d-1:0]                 out0,
  output logic [d-1:0]                 out1,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [15:0]                  enc_count
);

  localparam int unsigned N_RND = g4_enc_n_rnd(d);

  logic             rnd_ok;
  logic [N_RND-1:0] r_cur;
  logic             acc;
  logic             b_adv;
  logic             b_load;

  logic             a_valid;
  g4_t              a_x;
  logic [N_RND-1:0] a_r;
  logic             b_valid;

  g4_t              sh0;
  logic [d-1:0]     b0_nxt;
  logic [d-1:0]     b1_nxt;

`ifdef MSK_ENC_PRNG_EN
  logic [63:0] prng_state;
  logic        unused_ext;

  msk_g4_prng_xs64 u_prng (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (acc),
    .seed  (PRNG_SEED),
    .state (prng_state)
  );

  assign unused_ext = ^{rnd, rnd_valid, prng_state};
  assign rnd_ok     = 1'b1;
  assign r_cur      = prng_state[N_RND-1:0];
  assign rnd_ready  = 1'b0;
`else
  logic unused_seed;

  assign unused_seed = ^PRNG_SEED;
  assign rnd_ok      = rnd_valid;
  assign r_cur       = rnd;
  assign rnd_ready   = acc;
`endif

  // rst_n gates the handshake so nothing is offered while reset is held.
  assign b_adv     = !b_valid | out_ready;
  assign in_ready  = rst_n & rnd_ok & (!a_valid | b_adv);
  assign acc       = in_valid & in_ready;
  assign b_load    = a_valid & b_adv;
  assign out_valid = b_valid;

  // Share 0 folds every mask into x using stage A registers only.
  always_comb begin
    sh0    = a_x;
    b0_nxt = '0;
    b1_nxt = '0;
    for (int unsigned i = 1; i < d; i++) begin
      sh0       = sh0 ^ a_r[2*(i-1) +: 2];
      b0_nxt[i] = a_r[2*(i-1)];
      b1_nxt[i] = a_r[2*(i-1)+1];
    end
    b0_nxt[0] = sh0[0];
    b1_nxt[0] = sh0[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid <= 1'b0;
      a_x     <= '0;
      a_r     <= '0;
    end else begin
      if (acc) begin
        a_valid <= 1'b1;
        a_x     <= in_data;
        a_r     <= r_cur;
      end else if (b_load) begin
        a_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_valid <= 1'b0;
      out0    <= '0;
      out1    <= '0;
    end else begin
      if (b_load) begin
        b_valid <= 1'b1;
        out0    <= b0_nxt;
        out1    <= b1_nxt;
      end else if (b_adv) begin
        b_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_count <= '0;
    end else if (b_valid & out_ready) begin
      enc_count <= enc_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_msk_g4_encoder.sv
// Scoreboard bench for msk_g4_encoder: accepts push expected items, a negedge
// monitor pops and checks every delivered sharing.
module tb_msk_g4_encoder;

`ifdef MSK_ENC_PRNG_EN
  localparam int unsigned D = 3;
`else
  localparam int unsigned D = 2;
`endif
  localparam int unsigned NR = 2 * (D - 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [NR-1:0] rnd;
  logic          rnd_valid;
  logic          rnd_ready;
  logic [D-1:0]  out0;
  logic [D-1:0]  out1;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   enc_count;

  always #5 clk = ~clk;

  msk_g4_encoder #(.d(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rnd       (rnd),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .out0      (out0),
    .out1      (out1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .enc_count (enc_count)
  );

  typedef struct {
    logic [1:0]  x;
    logic [63:0] r;
  } item_t;

  item_t       exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_count = '0;
  int          cyc = 0;
  logic        hold_prev = 1'b0;
  logic [D-1:0] p0, p1;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Monitor: handshakes seen at negedge complete on the following posedge.
  always @(negedge clk) begin
    item_t       it;
    item_t       acc_it;
    logic [1:0]  s, rec;
    logic [D-1:0] e0, e1;
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      chk("enc_count", {48'd0, enc_count}, {48'd0, exp_count});
      if (hold_prev) begin
        chk("hold_valid", {63'd0, out_valid}, 64'd1);
        chk("hold_out0", {{(64-D){1'b0}}, out0}, {{(64-D){1'b0}}, p0});
        chk("hold_out1", {{(64-D){1'b0}}, out1}, {{(64-D){1'b0}}, p1});
      end
      if (in_valid && in_ready) begin
        acc_it.x = in_data;
        acc_it.r = 64'(rnd);
        exp_q.push_back(acc_it);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", {63'd0, out_valid}, 64'd0);
        end else begin
          it  = exp_q.pop_front();
          rec = '0;
          for (int unsigned i = 0; i < D; i++) rec = rec ^ {out1[i], out0[i]};
          chk("recombine", {62'd0, rec}, {62'd0, it.x});
`ifndef MSK_ENC_PRNG_EN
          s = it.x;
          e0 = '0;
          e1 = '0;
          for (int unsigned i = 1; i < D; i++) begin
            e0[i] = it.r[2*(i-1)];
            e1[i] = it.r[2*(i-1)+1];
            s = s ^ {e1[i], e0[i]};
          end
          e0[0] = s[0];
          e1[0] = s[1];
          chk("share_out0", {{(64-D){1'b0}}, out0}, {{(64-D){1'b0}}, e0});
          chk("share_out1", {{(64-D){1'b0}}, out1}, {{(64-D){1'b0}}, e1});
`endif
        end
        exp_count = exp_count + 16'd1;
      end
      hold_prev = out_valid && !out_ready;
      p0 = out0;
      p1 = out1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] x, input logic [NR-1:0] r);
    in_data   = x;
    rnd       = r;
    in_valid  = 1'b1;
    rnd_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        tick();
        in_valid = 1'b0;
        return;
      end
      tick();
    end
    chk("send_timeout", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    tick();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int acc_n;
    int c0;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    rnd_valid = 1'b1;
    out_ready = 1'b1;
    in_data   = 2'b11;
    rnd       = '1;

    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out0", 64'(out0), 64'd0);
    chk("rst_out1", 64'(out1), 64'd0);
    chk("rst_enc_count", 64'(enc_count), 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_rnd_ready", {63'd0, rnd_ready}, 64'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

`ifndef MSK_ENC_PRNG_EN
    // Directed d=2 example with latency, first-cycle accept and count.
    in_data   = 2'b10;
    rnd       = 2'b01;
    in_valid  = 1'b1;
    rnd_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("first_cycle_ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_t1_valid", {63'd0, out_valid}, 64'd0);
    tick();
    @(negedge clk);
    chk("lat_t2_valid", {63'd0, out_valid}, 64'd1);
    chk("ex_out0", 64'(out0), 64'b11);
    chk("ex_out1", 64'(out1), 64'b01);
    tick();
    @(negedge clk);
    chk("ex_count", 64'(enc_count), 64'd1);
    tick();

    // Back-to-back stream of 8.
    c0 = cyc;
    for (int k = 0; k < 8; k++) send(2'($urandom), NR'($urandom));
    chk("stream_cycles", 64'(cyc - c0), 64'd8);
    drain();

    // Stall: out_ready low for 5 cycles.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    rnd_valid = 1'b1;
    in_data   = 2'($urandom);
    rnd       = NR'($urandom);
    acc_n     = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (in_ready) acc_n++;
      tick();
      in_data = 2'($urandom);
      rnd     = NR'($urandom);
    end
    chk("stall_accepts", 64'(acc_n), 64'd2);
    @(negedge clk);
    chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    send(2'($urandom), NR'($urandom));
    drain();

    // Randomness unavailable blocks acceptance.
    in_valid  = 1'b1;
    rnd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("norand_in_ready", {63'd0, in_ready}, 64'd0);
      chk("norand_rnd_ready", {63'd0, rnd_ready}, 64'd0);
      tick();
    end
    rnd_valid = 1'b1;
    @(negedge clk);
    chk("rand_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rand_rnd_ready", {63'd0, rnd_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    drain();
`else
    // PRNG build: long stream across the enc_count wrap.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    acc_n     = 0;
    for (int k = 0; k < 72000; k++) begin
      in_data = 2'($urandom);
      @(negedge clk);
      if (in_ready) acc_n++;
      if (k == 10) chk("prng_rnd_ready", {63'd0, rnd_ready}, 64'd0);
      tick();
      if (acc_n == 70000) break;
    end
    in_valid = 1'b0;
    chk("prng_accepts", 64'(acc_n), 64'd70000);
    drain();
    chk("wrap_count", 64'(enc_count), 64'd4464);
`endif

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom % 4) != 0;
      rnd_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      in_data   = 2'($urandom);
      rnd       = NR'($urandom);
      tick();
    end
    drain();

    // Reset while both stages hold data.
    out_ready = 1'b0;
    send(2'($urandom), NR'($urandom));
    send(2'($urandom), NR'($urandom));
    @(negedge clk);
    chk("full_out_valid", {63'd0, out_valid}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_enc_count", 64'(enc_count), 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd0);
    exp_q.delete();
    exp_count = '0;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    @(negedge clk);
    chk("post_rst_quiet", {63'd0, out_valid}, 64'd0);
    send(2'($urandom), NR'($urandom));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
